// File: rtl/flag_mon_pkg.sv
// rtl/flag_mon_pkg.sv - shared state encoding for the windowed flag monitor
package flag_mon_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AT1     = 3'd1,
    AT0     = 3'd2,
    INVALID = 3'd3,
    STORE1  = 3'd4,
    STORE0  = 3'd5,
    ERR     = 3'd6
  } state_t;

endpackage

// File: rtl/flag_window_ch.sv
// rtl/flag_window_ch.sv - one channel: window FSM, run-length check, capture and error counter
import flag_mon_pkg::*;

module flag_window_ch #(
  parameter int MIN_LEN = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_window,
  input  logic             i_flag_in,
  input  logic             i_cnt_clr,
  output logic             o_flag_out,
  output logic             o_upd,
  output logic             o_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int               LEN_W   = $clog2(MIN_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_next;
  logic             w_match;

  assign w_match = ((r_state == AT1) == i_flag_in);

  always_comb begin
    w_next     = IDLE;
    w_len_next = r_len;
    case (r_state)
      // Single-cycle result states behave like IDLE so a new window may open immediately
      IDLE, STORE1, STORE0, ERR: begin
        if (i_window) begin
          w_next     = i_flag_in ? AT1 : AT0;
          w_len_next = LEN_W'(1);
        end
      end
      AT1, AT0: begin
        if (i_window) begin
          if (w_match) begin
            w_next = r_state;
            if (r_len < LEN_MIN) w_len_next = r_len + 1'b1;
          end else begin
            w_next = INVALID;
          end
        end else if (r_len >= LEN_MIN) begin
          w_next = (r_state == AT1) ? STORE1 : STORE0;
        end else begin
          w_next = ERR;
        end
      end
      INVALID: w_next = i_window ? INVALID : ERR;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_len      <= '0;
      o_flag_out <= 1'b0;
      o_upd      <= 1'b0;
      o_err      <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      r_state <= w_next;
      r_len   <= w_len_next;
      o_upd   <= (w_next == STORE1) || (w_next == STORE0);
      o_err   <= (w_next == ERR);
      if (w_next == STORE1)      o_flag_out <= 1'b1;
      else if (w_next == STORE0) o_flag_out <= 1'b0;
      // Count the visible err pulse; a clear in the same cycle takes priority
      if (i_cnt_clr)                        o_err_cnt <= '0;
      else if (o_err && o_err_cnt != CNT_MAX) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/flag_window_monitor.sv
// rtl/flag_window_monitor.sv - N independent windowed flag monitors with packed outputs
import flag_mon_pkg::*;

module flag_window_monitor #(
  parameter int N_CH    = 4,
  parameter int MIN_LEN = 1,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       i_window,
  input  logic [N_CH-1:0]       i_flag_in,
  input  logic                  i_cnt_clr,
  output logic [N_CH-1:0]       o_flag_out,
  output logic [N_CH-1:0]       o_upd,
  output logic [N_CH-1:0]       o_err,
  output logic [N_CH*CNT_W-1:0] o_err_cnt
);

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      flag_window_ch #(
        .MIN_LEN (MIN_LEN),
        .CNT_W   (CNT_W)
      ) u_ch (
        .clk        (clk),
        .reset      (reset),
        .i_window   (i_window[g]),
        .i_flag_in  (i_flag_in[g]),
        .i_cnt_clr  (i_cnt_clr),
        .o_flag_out (o_flag_out[g]),
        .o_upd      (o_upd[g]),
        .o_err      (o_err[g]),
        .o_err_cnt  (o_err_cnt[g*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_flag_window_monitor.sv
// tb/tb_flag_window_monitor.sv - scenario and randomized checks against a window-level model
module tb_flag_window_monitor;

  localparam int N_CH    = 4;
  localparam int MIN_LEN = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N_CH-1:0]       i_window = '0;
  logic [N_CH-1:0]       i_flag_in = '0;
  logic                  i_cnt_clr = 1'b0;
  logic [N_CH-1:0]       o_flag_out;
  logic [N_CH-1:0]       o_upd;
  logic [N_CH-1:0]       o_err;
  logic [N_CH*CNT_W-1:0] o_err_cnt;

  int errors = 0;
  int checks = 0;

  // Model: each open window is summarised by its length, first value and whether it stayed constant
  logic [N_CH-1:0] m_flag = '0;
  logic [N_CH-1:0] m_upd  = '0;
  logic [N_CH-1:0] m_err  = '0;
  int              m_cnt   [N_CH];
  int              m_len   [N_CH];
  bit              m_first [N_CH];
  bit              m_same  [N_CH];

  flag_window_monitor #(.N_CH(N_CH), .MIN_LEN(MIN_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_window   (i_window),
    .i_flag_in  (i_flag_in),
    .i_cnt_clr  (i_cnt_clr),
    .o_flag_out (o_flag_out),
    .o_upd      (o_upd),
    .o_err      (o_err),
    .o_err_cnt  (o_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [N_CH-1:0] win, input logic [N_CH-1:0] flg,
                      input logic clr, input logic rst);
    @(negedge clk);
    i_window  = win;
    i_flag_in = flg;
    i_cnt_clr = clr;
    reset     = rst;
    @(posedge clk);
    for (int c = 0; c < N_CH; c++) begin
      if (rst) begin
        m_flag[c] = 1'b0; m_upd[c] = 1'b0; m_err[c] = 1'b0;
        m_cnt[c] = 0; m_len[c] = 0; m_first[c] = 1'b0; m_same[c] = 1'b0;
      end else begin
        if (clr)                               m_cnt[c] = 0;
        else if (m_err[c] && m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
        m_upd[c] = 1'b0;
        m_err[c] = 1'b0;
        if (win[c]) begin
          if (m_len[c] == 0) begin
            m_first[c] = flg[c];
            m_same[c]  = 1'b1;
          end else if (flg[c] != m_first[c]) begin
            m_same[c] = 1'b0;
          end
          m_len[c] = m_len[c] + 1;
        end else if (m_len[c] > 0) begin
          if (m_same[c] && m_len[c] >= MIN_LEN) begin
            m_flag[c] = m_first[c];
            m_upd[c]  = 1'b1;
          end else begin
            m_err[c] = 1'b1;
          end
          m_len[c] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step('0, '0, 1'b0, 1'b1);
    step('0, '0, 1'b0, 1'b1);
    checks++;
    if ({o_flag_out, o_upd, o_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {o_flag_out, o_upd, o_err});
    end
    checks++;
    if (o_err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_err_cnt got=%h exp=0", o_err_cnt);
    end
    step('0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_capture();
    repeat (4) step(4'b0001, 4'b0001, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    checks++;
    if (o_flag_out[0] !== 1'b1) begin
      errors++; $display("FAIL capture_flag got=%b exp=1", o_flag_out[0]);
    end
    checks++;
    if (o_upd !== 4'b0001) begin
      errors++; $display("FAIL capture_upd got=%b exp=0001", o_upd);
    end
    checks++;
    if (o_err !== 4'b0000) begin
      errors++; $display("FAIL capture_err got=%b exp=0000", o_err);
    end
  endtask

  task automatic test_short();
    repeat (2) step(4'b0001, 4'b0000, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    checks++;
    if (o_err !== 4'b0001 || o_upd !== 4'b0000) begin
      errors++; $display("FAIL short_pulses got err=%b upd=%b exp err=0001 upd=0000", o_err, o_upd);
    end
    checks++;
    if (o_flag_out[0] !== 1'b1) begin
      errors++; $display("FAIL short_flag_hold got=%b exp=1", o_flag_out[0]);
    end
    step('0, '0, 1'b0, 1'b0);
    checks++;
    if (o_err_cnt[3:0] !== 4'd1) begin
      errors++; $display("FAIL short_err_cnt got=%0d exp=1", o_err_cnt[3:0]);
    end
  endtask

  task automatic test_invalid();
    logic [4:0] pat;
    pat = 5'b11100;
    for (int i = 0; i < 5; i++) step(4'b0010, {2'b00, pat[i], 1'b0}, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    checks++;
    if (o_err[1] !== 1'b1 || o_upd[1] !== 1'b0) begin
      errors++; $display("FAIL invalid_pulses got err=%b upd=%b exp err=1 upd=0", o_err[1], o_upd[1]);
    end
    checks++;
    if (o_flag_out[1] !== 1'b0) begin
      errors++; $display("FAIL invalid_flag got=%b exp=0", o_flag_out[1]);
    end
  endtask

  task automatic test_back_to_back();
    repeat (4) step(4'b0100, 4'b0100, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    checks++;
    if (o_upd !== 4'b0100 || o_flag_out[2] !== 1'b1) begin
      errors++; $display("FAIL b2b_first got upd=%b flag=%b exp upd=0100 flag=1", o_upd, o_flag_out[2]);
    end
    repeat (4) step(4'b0100, 4'b0000, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    checks++;
    if (o_upd !== 4'b0100 || o_flag_out[2] !== 1'b0) begin
      errors++; $display("FAIL b2b_second got upd=%b flag=%b exp upd=0100 flag=0", o_upd, o_flag_out[2]);
    end
  endtask

  task automatic test_saturate();
    for (int w = 0; w < 17; w++) begin
      step(4'b1000, 4'b0000, 1'b0, 1'b0);
      step(4'b1000, 4'b1000, 1'b0, 1'b0);
      step('0, '0, 1'b0, 1'b0);
    end
    step('0, '0, 1'b0, 1'b0);
    checks++;
    if (o_err_cnt[15:12] !== 4'd15) begin
      errors++; $display("FAIL saturate_cnt got=%0d exp=15", o_err_cnt[15:12]);
    end
    step('0, '0, 1'b1, 1'b0);
    checks++;
    if (o_err_cnt !== '0) begin
      errors++; $display("FAIL clear_all got=%h exp=0", o_err_cnt);
    end
    step(4'b1000, 4'b0000, 1'b0, 1'b0);
    step(4'b1000, 4'b1000, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    checks++;
    if (o_err[3] !== 1'b1) begin
      errors++; $display("FAIL clr_race_pulse got=%b exp=1", o_err[3]);
    end
    step('0, '0, 1'b1, 1'b0);
    checks++;
    if (o_err_cnt[15:12] !== 4'd0) begin
      errors++; $display("FAIL clr_wins got=%0d exp=0", o_err_cnt[15:12]);
    end
  endtask

  task automatic test_reset_mid_window();
    repeat (2) step(4'b1111, 4'b1010, 1'b0, 1'b0);
    step(4'b1111, 4'b1010, 1'b0, 1'b1);
    checks++;
    if ({o_flag_out, o_upd, o_err} !== '0 || o_err_cnt !== '0) begin
      errors++; $display("FAIL midreset_outputs got=%h cnt=%h exp=0", {o_flag_out, o_upd, o_err}, o_err_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 4'b1010, 1'b0, 1'b0);
      checks++;
      if ({o_flag_out, o_upd, o_err} !== '0) begin
        errors++; $display("FAIL midreset_quiet cycle=%0d got=%h exp=0", i, {o_flag_out, o_upd, o_err});
      end
    end
    step('0, '0, 1'b0, 1'b0);
    checks++;
    if (o_upd !== 4'b1111 || o_err !== 4'b0000 || o_flag_out !== 4'b1010) begin
      errors++; $display("FAIL midreset_capture got upd=%b err=%b flag=%b exp upd=1111 err=0000 flag=1010",
                         o_upd, o_err, o_flag_out);
    end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] rw;
    logic [N_CH-1:0] rf;
    logic            rc;
    logic            rr;
    rw = '0;
    rf = '0;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(3) == 0) rw[c] = ~rw[c];
        if ($urandom_range(4) == 0) rf[c] = ~rf[c];
      end
      rc = ($urandom_range(49) == 0);
      rr = ($urandom_range(199) == 0);
      step(rw, rf, rc, rr);
      checks++;
      if (o_flag_out !== m_flag || o_upd !== m_upd || o_err !== m_err) begin
        errors++;
        $display("FAIL random_pulses n=%0d got flag=%b upd=%b err=%b exp flag=%b upd=%b err=%b",
                 n, o_flag_out, o_upd, o_err, m_flag, m_upd, m_err);
      end
      for (int c = 0; c < N_CH; c++) begin
        checks++;
        if (o_err_cnt[c*CNT_W +: CNT_W] !== CNT_W'(m_cnt[c])) begin
          errors++;
          $display("FAIL random_cnt n=%0d ch=%0d got=%0d exp=%0d", n, c, o_err_cnt[c*CNT_W +: CNT_W], m_cnt[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_short();
    test_invalid();
    test_back_to_back();
    test_saturate();
    test_reset_mid_window();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
